// File: rtl/output_port_scheduler_if.sv
// Request/grant and credit-return signals between the input side, the downstream
// credit source and the output port scheduler.
interface output_port_scheduler_if #(
   parameter int NUM_PORTS = 5,
   parameter int NUM_VC    = 4,
   parameter int VC_BITS   = $clog2(NUM_VC)
);
   logic [NUM_PORTS-1:0] req;
   logic [VC_BITS-1:0]   req_vc [NUM_PORTS];
   logic [NUM_PORTS-1:0] req_tail;
   logic                 credit_valid;
   logic [VC_BITS-1:0]   credit_vc;
   logic [NUM_PORTS-1:0] grant;
   logic                 grant_valid;
   logic [VC_BITS-1:0]   grant_vc;
   logic                 locked;
   logic [NUM_VC-1:0]    vc_has_credit;
   logic                 credit_err;

   modport master (
      output req, req_vc, req_tail, credit_valid, credit_vc,
      input  grant, grant_valid, grant_vc, locked, vc_has_credit, credit_err
   );

   modport slave (
      input  req, req_vc, req_tail, credit_valid, credit_vc,
      output grant, grant_valid, grant_vc, locked, vc_has_credit, credit_err
   );
endinterface

// File: rtl/output_port_scheduler.sv
// Round-robin switch allocator for one output port: wormhole locking for multi-flit
// packets and per-VC downstream credit counters.
module output_port_scheduler #(
   parameter int NUM_PORTS = 5,
   parameter int NUM_VC    = 4,
   parameter int BUF_DEPTH = 4,
   parameter int VC_BITS   = $clog2(NUM_VC),
   parameter int CNT_BITS  = $clog2(BUF_DEPTH + 1)
) (
   input logic                clk,
   input logic                reset,
   output_port_scheduler_if.slave bus
);
   localparam int PTR_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t               state_reg;
   logic [PTR_BITS-1:0]  owner_reg;
   logic [PTR_BITS-1:0]  rr_ptr_reg;
   logic [VC_BITS-1:0]   owner_vc_reg;
   logic [CNT_BITS-1:0]  credit_reg [NUM_VC];
   logic                 credit_err_reg;

   logic [NUM_VC-1:0]    has_credit;
   logic [NUM_VC-1:0]    xfer_on_vc;
   logic [NUM_VC-1:0]    ret_on_vc;
   logic [NUM_VC-1:0]    overflow;
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] grant_next;
   logic [PTR_BITS-1:0]  win_port;
   logic [VC_BITS-1:0]   xfer_vc;
   logic                 xfer;
   logic                 xfer_tail;
   logic                 found;
   int                   cand;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
         assign has_credit[gi] = (credit_reg[gi] != '0);
         assign xfer_on_vc[gi] = xfer && (xfer_vc == VC_BITS'(gi));
         assign ret_on_vc[gi]  = bus.credit_valid && (bus.credit_vc == VC_BITS'(gi));
         // A return that coincides with a send on the same VC is a net no-op, never an overflow.
         assign overflow[gi]   = ret_on_vc[gi] && !xfer_on_vc[gi] &&
                                 (credit_reg[gi] == CNT_BITS'(BUF_DEPTH));
      end
      for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign eligible[gi] = bus.req[gi] && has_credit[bus.req_vc[gi]];
      end
   endgenerate

   always_comb begin
      grant_next = '0;
      win_port   = owner_reg;
      found      = 1'b0;
      cand       = 0;
      if (state_reg == IDLE) begin
         for (int k = 1; k <= NUM_PORTS; k++) begin
            cand = int'(rr_ptr_reg) + k;
            if (cand >= NUM_PORTS) cand = cand - NUM_PORTS;
            if (!found && eligible[PTR_BITS'(cand)]) begin
               found    = 1'b1;
               win_port = PTR_BITS'(cand);
            end
         end
         grant_next[win_port] = found;
      end else begin
         grant_next[owner_reg] = bus.req[owner_reg] && has_credit[owner_vc_reg];
      end
   end

   assign xfer      = |grant_next;
   assign xfer_vc   = (state_reg == IDLE) ? bus.req_vc[win_port] : owner_vc_reg;
   assign xfer_tail = bus.req_tail[win_port];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= '0;
         owner_vc_reg   <= '0;
         rr_ptr_reg     <= PTR_BITS'(NUM_PORTS - 1);
         credit_err_reg <= 1'b0;
      end else begin
         if (|overflow) credit_err_reg <= 1'b1;
         if (xfer) begin
            if (xfer_tail) begin
               state_reg  <= IDLE;
               rr_ptr_reg <= win_port;
            end else if (state_reg == IDLE) begin
               state_reg    <= LOCKED;
               owner_reg    <= win_port;
               owner_vc_reg <= xfer_vc;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (reset)
            credit_reg[v] <= CNT_BITS'(BUF_DEPTH);
         else if (xfer_on_vc[v] && !ret_on_vc[v])
            credit_reg[v] <= credit_reg[v] - CNT_BITS'(1);
         else if (ret_on_vc[v] && !xfer_on_vc[v] && !overflow[v])
            credit_reg[v] <= credit_reg[v] + CNT_BITS'(1);
      end
   end

   assign bus.grant         = grant_next;
   assign bus.grant_valid   = xfer;
   assign bus.grant_vc      = xfer ? xfer_vc : '0;
   assign bus.locked        = (state_reg == LOCKED);
   assign bus.vc_has_credit = has_credit;
   assign bus.credit_err    = credit_err_reg;
endmodule

// File: tb/tb_output_port_scheduler.sv
// Bench for output_port_scheduler: directed scenarios plus random traffic, all checked
// against a packet-level model of arbitration and credit accounting.
module tb_output_port_scheduler;
   localparam int NP = 5;
   localparam int NV = 4;
   localparam int BD = 4;
   localparam int VB = 2;
   localparam int W  = NP + 1 + VB + 1 + NV + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   output_port_scheduler_if #(.NUM_PORTS(NP), .NUM_VC(NV)) bus ();

   output_port_scheduler #(.NUM_PORTS(NP), .NUM_VC(NV), .BUF_DEPTH(BD)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // model state: packet ownership, last tail winner, free downstream slots
   bit            m_locked;
   int            m_owner;
   logic [VB-1:0] m_owner_vc;
   int            m_last;
   int            m_cred [NV];
   bit            m_err;

   int            e_port;
   logic [VB-1:0] e_vc;
   logic [W-1:0]  exp_vec;
   logic [W-1:0]  obs_vec;
   int            checks = 0;
   int            errors = 0;

   function automatic void model_reset();
      m_locked   = 0;
      m_owner    = 0;
      m_owner_vc = '0;
      m_last     = NP - 1;
      for (int v = 0; v < NV; v++) m_cred[v] = BD;
      m_err = 0;
   endfunction

   function automatic logic [NP*VB-1:0] all_vc(input logic [VB-1:0] v);
      return {NP{v}};
   endfunction

   task automatic evaluate();
      logic [NP-1:0] eg;
      logic [NV-1:0] vhc;
      eg     = '0;
      e_port = -1;
      e_vc   = '0;
      if (!m_locked) begin
         for (int k = 1; k <= NP; k++) begin
            int p;
            p = (m_last + k) % NP;
            if (e_port < 0 && bus.req[p] && m_cred[bus.req_vc[p]] > 0) e_port = p;
         end
         if (e_port >= 0) e_vc = bus.req_vc[e_port];
      end else if (bus.req[m_owner] && m_cred[m_owner_vc] > 0) begin
         e_port = m_owner;
         e_vc   = m_owner_vc;
      end
      if (e_port >= 0) eg[e_port] = 1'b1;
      for (int v = 0; v < NV; v++) vhc[v] = (m_cred[v] > 0);
      exp_vec = {eg, (e_port >= 0), e_vc, m_locked, vhc, m_err};
      obs_vec = {bus.grant, bus.grant_valid, bus.grant_vc, bus.locked, bus.vc_has_credit,
                 bus.credit_err};
   endtask

   task automatic advance();
      int  dvc;
      int  rv;
      bool_t_dummy: begin end
      if (reset) begin
         model_reset();
      end else begin
         dvc = -1;
         rv  = int'(bus.credit_vc);
         if (e_port >= 0) begin
            dvc = int'(e_vc);
            if (bus.req_tail[e_port]) begin
               m_locked = 0;
               m_last   = e_port;
            end else if (!m_locked) begin
               m_locked   = 1;
               m_owner    = e_port;
               m_owner_vc = e_vc;
            end
         end
         if (bus.credit_valid && rv == dvc) begin
            // send and return on one VC cancel out
         end else begin
            if (dvc >= 0) m_cred[dvc]--;
            if (bus.credit_valid) begin
               if (m_cred[rv] == BD) m_err = 1;
               else m_cred[rv]++;
            end
         end
      end
   endtask

   task automatic drive(input logic r, input logic [NP-1:0] rq, input logic [NP*VB-1:0] vcs,
                        input logic [NP-1:0] tl, input logic cv, input logic [VB-1:0] cvc);
      @(negedge clk);
      reset    = r;
      bus.req  = rq;
      for (int i = 0; i < NP; i++) bus.req_vc[i] = vcs[i*VB +: VB];
      bus.req_tail     = tl;
      bus.credit_valid = cv;
      bus.credit_vc    = cvc;
      #2;
      evaluate();
   endtask

   task automatic end_cycle();
      advance();
      @(posedge clk);
   endtask

   task automatic do_reset();
      drive(1'b1, '0, '0, '0, 1'b0, '0);
      end_cycle();
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset            = 1'b1;
      bus.req          = '0;
      bus.req_tail     = '0;
      bus.credit_valid = 1'b0;
      bus.credit_vc    = '0;
      for (int i = 0; i < NP; i++) bus.req_vc[i] = '0;
      @(posedge clk);
      model_reset();
      drive(1'b1, 5'b10110, all_vc(2'd0), 5'b11111, 1'b0, '0);
      checks++;
      if (obs_vec !== exp_vec)
         begin errors++; $display("FAIL reset_hold: got %h required %h", obs_vec, exp_vec); end
      end_cycle();
      drive(1'b0, '0, '0, '0, 1'b0, '0);
      checks++;
      if (obs_vec !== exp_vec)
         begin errors++; $display("FAIL reset_idle: got %h required %h", obs_vec, exp_vec); end
      checks++;
      if ({bus.grant, bus.locked, bus.vc_has_credit, bus.credit_err} !== {5'b0, 1'b0, 4'b1111, 1'b0})
         begin
            errors++;
            $display("FAIL reset_outputs: got %b required %b",
                     {bus.grant, bus.locked, bus.vc_has_credit, bus.credit_err}, 11'b00000_0_1111_0);
         end
      end_cycle();
   endtask

   task automatic test_round_robin();
      logic [NP-1:0] want [4] = '{5'b00010, 5'b00100, 5'b10000, 5'b00001};
      do_reset();
      for (int c = 0; c < 4; c++) begin
         if (c < 3) drive(1'b0, 5'b10110, all_vc(2'd0), 5'b11111, 1'b0, '0);
         else       drive(1'b0, 5'b11111, all_vc(2'd1), 5'b11111, 1'b0, '0);
         checks++;
         if (obs_vec !== exp_vec)
            begin errors++; $display("FAIL rr_model c%0d: got %h required %h", c, obs_vec, exp_vec); end
         checks++;
         if (bus.grant !== want[c])
            begin errors++; $display("FAIL rr_grant c%0d: got %b required %b", c, bus.grant, want[c]); end
         end_cycle();
      end
   endtask

   task automatic test_lock();
      logic [NP:0] want [4] = '{{5'b00100, 1'b0}, {5'b00100, 1'b1}, {5'b00100, 1'b1}, {5'b00001, 1'b0}};
      do_reset();
      drive(1'b0, 5'b00010, all_vc(2'd0), 5'b11111, 1'b0, '0);
      end_cycle();
      for (int c = 0; c < 4; c++) begin
         if (c < 3)
            drive(1'b0, 5'b00101, {2'd0, 2'd0, 2'd1, 2'd0, 2'd0},
                  {2'b00, (c == 2), 2'b01}, 1'b0, '0);
         else
            drive(1'b0, 5'b00001, all_vc(2'd0), 5'b11111, 1'b0, '0);
         checks++;
         if (obs_vec !== exp_vec)
            begin errors++; $display("FAIL lock_model c%0d: got %h required %h", c, obs_vec, exp_vec); end
         checks++;
         if ({bus.grant, bus.locked} !== want[c])
            begin
               errors++;
               $display("FAIL lock_seq c%0d: got %b required %b", c, {bus.grant, bus.locked}, want[c]);
            end
         end_cycle();
      end
   endtask

   task automatic test_credit_exhaust();
      do_reset();
      for (int c = 0; c < 7; c++) begin
         drive(1'b0, 5'b00010, all_vc(2'd3), 5'b11111, (c == 5), 2'd3);
         checks++;
         if (obs_vec !== exp_vec)
            begin errors++; $display("FAIL credit_model c%0d: got %h required %h", c, obs_vec, exp_vec); end
         checks++;
         if (bus.grant_valid !== (c < 4 || c == 6))
            begin
               errors++;
               $display("FAIL credit_gv c%0d: got %b required %b", c, bus.grant_valid, (c < 4 || c == 6));
            end
         if (c == 5) begin
            checks++;
            if (bus.vc_has_credit[3] !== 1'b0)
               begin errors++; $display("FAIL credit_empty: got %b required 0", bus.vc_has_credit[3]); end
         end
         end_cycle();
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c < 6) drive(1'b0, 5'b00001, all_vc(2'd2), 5'b11111, (c == 1), 2'd2);
         else       drive(1'b0, 5'b00000, all_vc(2'd0), 5'b11111, (c == 6), 2'd0);
         checks++;
         if (obs_vec !== exp_vec)
            begin errors++; $display("FAIL simul_model c%0d: got %h required %h", c, obs_vec, exp_vec); end
         checks++;
         if ({bus.grant_valid, bus.credit_err} !== {(c < 5), (c > 6)})
            begin
               errors++;
               $display("FAIL simul_seq c%0d: got %b required %b", c,
                        {bus.grant_valid, bus.credit_err}, {(c < 5), (c > 6)});
            end
         end_cycle();
      end
   endtask

   task automatic test_reset_mid_packet();
      for (int c = 0; c < 3; c++) begin
         if (c < 2) drive((c == 1), 5'b01000, all_vc(2'd1), 5'b00000, 1'b0, '0);
         else       drive(1'b0, 5'b11111, all_vc(2'd0), 5'b11111, 1'b0, '0);
         checks++;
         if (obs_vec !== exp_vec)
            begin errors++; $display("FAIL midrst_model c%0d: got %h required %h", c, obs_vec, exp_vec); end
         if (c == 2) begin
            checks++;
            if ({bus.grant, bus.locked, bus.vc_has_credit, bus.credit_err} !== 11'b00001_0_1111_0)
               begin
                  errors++;
                  $display("FAIL midrst_state: got %b required %b",
                           {bus.grant, bus.locked, bus.vc_has_credit, bus.credit_err}, 11'b00001_0_1111_0);
               end
         end
         end_cycle();
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         drive(($urandom_range(0, 99) == 0), NP'($urandom), (NP*VB)'($urandom),
               NP'($urandom | $urandom), ($urandom_range(0, 3) == 0), VB'($urandom));
         checks++;
         if (obs_vec !== exp_vec)
            begin errors++; $display("FAIL random c%0d: got %h required %h", c, obs_vec, exp_vec); end
         end_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_lock();
      test_credit_exhaust();
      test_simultaneous();
      test_reset_mid_packet();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/output_port_scheduler.md
OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 Parameter NUM_PORTS, 5, number of input ports competing for this output port.
REQ-002 Parameter NUM_VC, 4, number of downstream VCs on this output port.
REQ-003 Parameter BUF_DEPTH, 4, downstream buffer depth per VC in flits, which is also the initial credit count.
REQ-004 Parameter VC_BITS, $clog2(NUM_VC), width of a VC index; CNT_BITS is $clog2(BUF_DEPTH+1).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 req  input  NUM_PORTS  bit i set means input port i has a flit for this output.
REQ-008 req_vc  input  VC_BITS per port (unpacked [NUM_PORTS-1:0])  downstream VC allocated to port i's packet.
REQ-009 req_tail  input  NUM_PORTS  bit i set means port i's current flit is a tail (single-flit packets have head=tail).
REQ-010 credit_valid  input  1  a downstream credit return is presented this cycle.
REQ-011 credit_vc  input  VC_BITS  VC receiving the returned credit.
REQ-012 grant  output  NUM_PORTS  one-hot or zero; winning input port this cycle.
REQ-013 grant_valid  output  1  a flit traverses the switch this cycle (equals |grant).
REQ-014 grant_vc  output  VC_BITS  downstream VC of the granted flit; 0 when grant_valid=0.
REQ-015 locked  output  1  output is held by a multi-flit packet in progress.
REQ-016 vc_has_credit  output  NUM_VC  bit v set when credit count of VC v > 0.
REQ-017 credit_err  output  1  sticky flag: credit returned to a VC already at BUF_DEPTH.

Function
REQ-018 Block holds: state {IDLE, LOCKED}, owner (port index), owner_vc, round-robin pointer rr_ptr, one CNT_BITS credit counter per VC, credit_err.
REQ-019 grant, grant_valid, grant_vc are combinational from current state and inputs; a transfer occurs in every cycle with grant_valid=1.
REQ-020 IDLE: eligible[i] = req[i] AND credit[req_vc[i]] > 0.
REQ-021 IDLE: grant the first eligible port searching rr_ptr+1, rr_ptr+2, ... modulo NUM_PORTS; no eligible port means grant=0.
REQ-022 IDLE transfer with req_tail=0: next state LOCKED; owner and owner_vc latch the winner and its req_vc.
REQ-023 IDLE transfer with req_tail=1: stay IDLE (single-flit packet).
REQ-024 rr_ptr updates to the winning port on every tail transfer only; body flits and idle cycles leave rr_ptr unchanged.
REQ-025 LOCKED: grant only the owner, only when req[owner]=1 and credit[owner_vc] > 0; all other requests are ignored.
REQ-026 LOCKED: grant_vc = owner_vc; req_vc[owner] is ignored while locked.
REQ-027 LOCKED transfer with req_tail[owner]=1: next state IDLE; rr_ptr <= owner.
REQ-028 LOCKED with the owner stalled (no req or no credit): hold state; grant=0.
REQ-029 Credit update per cycle on each VC v: decrement by 1 if transfer on v, increment by 1 if credit_valid and credit_vc==v.
REQ-030 Both events on the same VC in the same cycle: count unchanged.
REQ-031 Increment alone on a VC at BUF_DEPTH: count stays BUF_DEPTH; credit_err <= 1 and stays set until reset.
REQ-032 Decrement never occurs at count 0, guaranteed by REQ-020/REQ-025; a returned credit is usable from the next cycle, not the same cycle.
REQ-033 locked = (state==LOCKED); vc_has_credit is derived from registered counts.

Reset
REQ-034 Reset state: IDLE, owner=0, owner_vc=0, rr_ptr=NUM_PORTS-1 so port 0 has first priority, every credit counter=BUF_DEPTH, credit_err=0.
REQ-035 Outputs during and after reset cycle: grant=0 unless requests present; locked=0; vc_has_credit all ones; credit_err=0.
REQ-036 Reset asserted mid-packet: abandons the lock and restores all credits in one cycle; reset has priority over every other update.

Verification
REQ-037 After reset, req=5'b10110 all tail on VC0 held 3 cycles -> grants 00010, 00100, 10000; rr_ptr ends at 4.
REQ-038 Port 2 sends a 3-flit packet on VC1 while port 0 also requests -> grant stays 00100 three cycles, locked=1 then 0, port 0 granted on fourth cycle.
REQ-039 Port 1 streams 5 single-flit packets on VC3 with no credit return -> 4 grants, then grant=0, vc_has_credit[3]=0; one credit return on VC3 -> grant resumes next cycle.
REQ-040 Transfer on VC2 with simultaneous credit return on VC2 at count 3 -> count remains 3; credit return to VC0 at 4 -> credit_err=1 and sticky.
REQ-041 Reset asserted during LOCKED, second flit of a 4-flit packet -> next cycle locked=0, all counts 4, rr_ptr=4, credit_err=0.
